// File: rtl/life_seq.sv
// Generation sequencer for the life datapath: paces generations, sweeps the cell
// counter while shifting, scans display rows in between. Optional macro: LIFE_SEQ_GEN_CNT_EN.
module life_seq #(
    parameter int X        = 8,
    parameter int Y        = 8,
    parameter int LOG2X    = 3,
    parameter int LOG2Y    = 3,
    parameter int GEN_DIV  = 1000000,
    parameter int SCAN_DIV = 1000,
    parameter int DIV_W    = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run_toggle,
    input  logic                   step,
    input  logic [2:0]             keys_in,
    output logic [2:0]             keys_out,
    output logic [LOG2X+LOG2Y-1:0] cnt,
    output logic                   nxt_bit,
    output logic                   row_valid,
    output logic                   running,
    output logic                   gen_done,
    output logic [15:0]            gen_count
);
    localparam int               CW        = LOG2X + LOG2Y;
    localparam logic [CW-1:0]    LAST_CELL = CW'(X * Y - 1);
    localparam logic [LOG2Y-1:0] LAST_ROW  = LOG2Y'(Y - 1);
    localparam logic [DIV_W-1:0] GEN_LOAD  = DIV_W'(GEN_DIV - 1);
    localparam logic [DIV_W-1:0] SCAN_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

    state_t           state, state_d;
    logic [DIV_W-1:0] gen_pre, gen_pre_d;
    logic [DIV_W-1:0] scan_pre, scan_pre_d;
    logic [CW-1:0]    cnt_d;
    logic [LOG2Y-1:0] row, row_nxt;
    logic             running_d, nxt_bit_d, row_valid_d, gen_done_d;
    logic [2:0]       keys_out_d;
    logic             scan_now, scan_next;

    assign scan_now  = (state == IDLE) || (state == WAIT);
    assign scan_next = (state_d == IDLE) || (state_d == WAIT);
    assign row       = cnt[CW-1:LOG2X];
    assign row_nxt   = (row == LAST_ROW) ? '0 : row + LOG2Y'(1);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                // A toggle in the same cycle as step wins; step is dropped.
                if (running)                 state_d = WAIT;
                else if (step && !run_toggle) state_d = SHIFT;
            end
            WAIT: begin
                if (!running)          state_d = IDLE;
                else if (gen_pre == '0) state_d = SHIFT;
            end
            SHIFT:   if (cnt == LAST_CELL) state_d = DONE;
            DONE:    state_d = running ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        running_d  = running ^ run_toggle;
        gen_pre_d  = gen_pre;
        scan_pre_d = scan_pre;
        cnt_d      = cnt;
        if (state_d == WAIT && state != WAIT) gen_pre_d = GEN_LOAD;
        else if (state == WAIT && gen_pre != '0) gen_pre_d = gen_pre - DIV_W'(1);

        // cnt is shared: row scan while idle/waiting, cell index while shifting.
        if (scan_now && scan_next) begin
            if (scan_pre == SCAN_LAST) begin
                scan_pre_d = '0;
                cnt_d      = {row_nxt, {LOG2X{1'b0}}};
            end else begin
                scan_pre_d = scan_pre + DIV_W'(1);
            end
        end else if (state == SHIFT && state_d == SHIFT) begin
            cnt_d = cnt + CW'(1);
        end else begin
            cnt_d      = '0;
            scan_pre_d = '0;
        end

        nxt_bit_d   = (state_d == SHIFT);
        row_valid_d = scan_next;
        gen_done_d  = (state_d == DONE);
        // Only pass keys when both this and the next cycle are outside a generation.
        keys_out_d  = (scan_now && scan_next) ? keys_in : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            running   <= 1'b0;
            gen_pre   <= '0;
            scan_pre  <= '0;
            cnt       <= '0;
            nxt_bit   <= 1'b0;
            row_valid <= 1'b1;
            gen_done  <= 1'b0;
            keys_out  <= 3'b000;
        end else begin
            running   <= running_d;
            gen_pre   <= gen_pre_d;
            scan_pre  <= scan_pre_d;
            cnt       <= cnt_d;
            nxt_bit   <= nxt_bit_d;
            row_valid <= row_valid_d;
            gen_done  <= gen_done_d;
            keys_out  <= keys_out_d;
        end
    end

`ifdef LIFE_SEQ_GEN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)                 gen_count <= 16'h0000;
        else if (state_d == DONE)  gen_count <= gen_count + 16'd1;
    end
`else
    assign gen_count = 16'h0000;
`endif

endmodule

// File: tb/tb_life_seq.sv
// Directed bench for life_seq: idle scan, single step, free-running generations,
// key gating, mid-shift reset and step/toggle corner cases.
module tb_life_seq;
    localparam int X = 8, Y = 8, LOG2X = 3, LOG2Y = 3;
    localparam int GEN_DIV = 10, SCAN_DIV = 4, DIV_W = 20;
`ifdef LIFE_SEQ_GEN_CNT_EN
    localparam int GC_EN = 1;
`else
    localparam int GC_EN = 0;
`endif

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   run_toggle = 1'b0;
    logic                   step = 1'b0;
    logic [2:0]             keys_in = 3'b000;
    logic [2:0]             keys_out;
    logic [LOG2X+LOG2Y-1:0] cnt;
    logic                   nxt_bit, row_valid, running, gen_done;
    logic [15:0]            gen_count;

    int n_chk  = 0;
    int n_fail = 0;
    int gens   = 0;

    life_seq #(.X(X), .Y(Y), .LOG2X(LOG2X), .LOG2Y(LOG2Y),
               .GEN_DIV(GEN_DIV), .SCAN_DIV(SCAN_DIV), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset(reset), .run_toggle(run_toggle), .step(step),
        .keys_in(keys_in), .keys_out(keys_out), .cnt(cnt), .nxt_bit(nxt_bit),
        .row_valid(row_valid), .running(running), .gen_done(gen_done),
        .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int gc(input int n);
        return (GC_EN != 0) ? n : 0;
    endfunction

    // Caller sits in the first WAIT cycle; leaves in the first SHIFT cycle.
    task automatic do_wait(input bit keys_test);
        for (int w = 0; w < GEN_DIV; w++) begin
            chk("wait_nxt", 32'(nxt_bit), 0);
            chk("wait_rv", 32'(row_valid), 1);
            if (keys_test && w == 2) keys_in = 3'b101;
            if (keys_test && w == 3) begin
                chk("wait_keys", 32'(keys_out), 5);
                keys_in = 3'b000;
            end
            tick();
        end
    endtask

    // Caller sits in the first SHIFT cycle; leaves in the cycle after DONE.
    task automatic do_shift(input int tog_at, input bit keys_test);
        if (keys_test) keys_in = 3'b101;
        for (int j = 0; j < X * Y; j++) begin
            chk("shift_nxt", 32'(nxt_bit), 1);
            chk("shift_cnt", 32'(cnt), j);
            chk("shift_rv", 32'(row_valid), 0);
            chk("shift_done", 32'(gen_done), 0);
            if (keys_test) chk("shift_keys", 32'(keys_out), 0);
            if (j == tog_at) run_toggle = 1'b1;
            tick();
            run_toggle = 1'b0;
        end
        gens++;
        chk("done_pulse", 32'(gen_done), 1);
        chk("done_nxt", 32'(nxt_bit), 0);
        chk("done_cnt", 32'(cnt), 0);
        chk("done_gc", 32'(gen_count), gc(gens));
        if (keys_test) chk("done_keys", 32'(keys_out), 0);
        tick();
        chk("post_done_pulse", 32'(gen_done), 0);
    endtask

    initial begin
        bit seen;
        tick();
        tick();
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_nxt", 32'(nxt_bit), 0);
        chk("rst_rv", 32'(row_valid), 1);
        chk("rst_keys", 32'(keys_out), 0);
        chk("rst_done", 32'(gen_done), 0);
        chk("rst_gc", 32'(gen_count), 0);
        chk("rst_run", 32'(running), 0);
        reset = 1'b0;

        // Idle scan: each row held SCAN_DIV cycles, wrapping after row 7.
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk("idle_cnt", 32'(cnt), 8 * ((k / SCAN_DIV) % Y));
            chk("idle_nxt", 32'(nxt_bit), 0);
            chk("idle_rv", 32'(row_valid), 1);
        end

        // Single step with a key held across the whole generation.
        step = 1'b1;
        tick();
        step = 1'b0;
        do_shift(-1, 1'b1);
        chk("step_idle_cnt", 32'(cnt), 0);
        chk("step_idle_rv", 32'(row_valid), 1);
        chk("step_idle_nxt", 32'(nxt_bit), 0);
        chk("key_dropped", 32'(keys_out), 0);
        tick();
        chk("key_after", 32'(keys_out), 5);
        keys_in = 3'b000;

        // Free run: three generations, the third stopped by a toggle mid-shift.
        run_toggle = 1'b1;
        tick();
        run_toggle = 1'b0;
        chk("run_on", 32'(running), 1);
        chk("run_idle_nxt", 32'(nxt_bit), 0);
        tick();
        do_wait(1'b1);
        do_shift(-1, 1'b0);
        do_wait(1'b0);
        do_shift(-1, 1'b0);
        do_wait(1'b0);
        do_shift(30, 1'b0);
        chk("run_off", 32'(running), 0);
        chk("run_stop_rv", 32'(row_valid), 1);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (nxt_bit) seen = 1'b1;
        end
        chk("stopped_no_shift", 32'(seen), 0);
        chk("gc_after_run", 32'(gen_count), gc(4));

        // Reset in the middle of a shift.
        run_toggle = 1'b1;
        tick();
        run_toggle = 1'b0;
        tick();
        do_wait(1'b0);
        for (int j = 0; j < 20; j++) tick();
        chk("pre_rst_cnt", 32'(cnt), 20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        gens = 0;
        chk("mid_rst_cnt", 32'(cnt), 0);
        chk("mid_rst_nxt", 32'(nxt_bit), 0);
        chk("mid_rst_run", 32'(running), 0);
        chk("mid_rst_done", 32'(gen_done), 0);
        chk("mid_rst_gc", 32'(gen_count), 0);
        chk("mid_rst_rv", 32'(row_valid), 1);
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (gen_done || nxt_bit) seen = 1'b1;
        end
        chk("rst_no_gen", 32'(seen), 0);

        // Step while running is ignored: WAIT still lasts GEN_DIV cycles.
        run_toggle = 1'b1;
        tick();
        run_toggle = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        do_wait(1'b0);
        do_shift(5, 1'b0);
        chk("step_run_off", 32'(running), 0);

        // Step together with run_toggle in IDLE: toggle wins.
        step = 1'b1;
        run_toggle = 1'b1;
        tick();
        step = 1'b0;
        run_toggle = 1'b0;
        chk("steptog_nxt", 32'(nxt_bit), 0);
        chk("steptog_run", 32'(running), 1);
        tick();
        chk("steptog_wait_nxt", 32'(nxt_bit), 0);
        run_toggle = 1'b1;
        tick();
        run_toggle = 1'b0;
        chk("wait_stop_run", 32'(running), 0);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (nxt_bit || gen_done) seen = 1'b1;
        end
        chk("wait_abort_no_shift", 32'(seen), 0);
        chk("gc_final", 32'(gen_count), gc(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
